// File: rtl/game_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | game_control_fsm: button conditioning, IDLE/RUN/DEAD game FSM, BCD score |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module game_control_fsm #(
  parameter int DEB_FRAMES     = 3,
  parameter int SCORE_DIV      = 6,
  parameter int RESTART_FRAMES = 30
) (
  input  logic        FrameClk,
  input  logic        rst,
  input  logic        btnJump,
  input  logic        btnDuck,
  input  logic        collision,
  output logic [1:0]  gameState,
  output logic        jump,
  output logic        duck,
  output logic [15:0] score,
  output logic [15:0] hiScore
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b10,
    DEAD = 2'b01
  } state_t;

  localparam logic [3:0] c_DEB_LAST   = 4'(DEB_FRAMES - 1);
  localparam logic [7:0] c_DIV_LAST   = 8'(SCORE_DIV - 1);
  localparam logic [7:0] c_LOCK_LEN   = 8'(RESTART_FRAMES);

  logic [1:0] w_btnRaw;
  logic [1:0] w_btnDebNext;
  logic [1:0] w_btnDebCur;

  assign w_btnRaw = {btnDuck, btnJump};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic       r_sync1;
    logic       r_sync2;
    logic       r_deb;
    logic [3:0] r_cnt;
    logic       w_cntHit;

    // The FSM consumes the value the debouncer is about to take, so a
    // debounced edge and its consequence land on the same frame edge.
    assign w_cntHit        = (r_sync2 != r_deb) && (r_cnt == c_DEB_LAST);
    assign w_btnDebNext[i] = r_deb ^ w_cntHit;
    assign w_btnDebCur[i]  = r_deb;

    always_ff @(posedge FrameClk or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_cnt   <= 4'd0;
      end else begin
        r_sync1 <= w_btnRaw[i];
        r_sync2 <= r_sync1;
        r_deb   <= w_btnDebNext[i];
        if ((r_sync2 == r_deb) || w_cntHit) begin
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  logic w_jumpEvt;
  logic w_duckLvl;

  assign w_jumpEvt = w_btnDebNext[0] & ~w_btnDebCur[0];
  assign w_duckLvl = w_btnDebNext[1];

  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (v[4*d +: 4] == 4'd9) begin
            res[4*d +: 4] = 4'd0;
          end else begin
            res[4*d +: 4] = v[4*d +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_jump;
  logic        w_jumpNext;
  logic        r_duck;
  logic        w_duckNext;
  logic [15:0] r_score;
  logic [15:0] w_scoreNext;
  logic [15:0] r_hiScore;
  logic [15:0] w_hiNext;
  logic [7:0]  r_div;
  logic [7:0]  w_divNext;
  logic [7:0]  r_lock;
  logic [7:0]  w_lockNext;

  always_ff @(posedge FrameClk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_jump    <= 1'b0;
      r_duck    <= 1'b0;
      r_score   <= 16'h0000;
      r_hiScore <= 16'h0000;
      r_div     <= 8'd0;
      r_lock    <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_jump    <= w_jumpNext;
      r_duck    <= w_duckNext;
      r_score   <= w_scoreNext;
      r_hiScore <= w_hiNext;
      r_div     <= w_divNext;
      r_lock    <= w_lockNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_jumpNext  = 1'b0;
    w_duckNext  = 1'b0;
    w_scoreNext = r_score;
    w_hiNext    = r_hiScore;
    w_divNext   = r_div;
    w_lockNext  = r_lock;
    case (r_state)
      IDLE: begin
        if (w_jumpEvt) begin
          w_stateNext = RUN;
          w_divNext   = 8'd0;
        end
      end
      RUN: begin
        // Collision wins: the same-frame jump and any score tick are dropped.
        if (collision) begin
          w_stateNext = DEAD;
          w_lockNext  = 8'd0;
          if (r_score > r_hiScore) begin
            w_hiNext = r_score;
          end
        end else begin
          w_jumpNext = w_jumpEvt;
          w_duckNext = w_duckLvl & ~w_jumpEvt;
          if (r_div == c_DIV_LAST) begin
            w_divNext   = 8'd0;
            w_scoreNext = bcdInc(r_score);
          end else begin
            w_divNext = r_div + 8'd1;
          end
        end
      end
      DEAD: begin
        if (r_lock != c_LOCK_LEN) begin
          w_lockNext = r_lock + 8'd1;
        end else if (w_jumpEvt) begin
          w_stateNext = RUN;
          w_scoreNext = 16'h0000;
          w_divNext   = 8'd0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign gameState = r_state;
  assign jump      = r_jump;
  assign duck      = r_duck;
  assign score     = r_score;
  assign hiScore   = r_hiScore;

endmodule
`default_nettype wire
